async_counter_block: RTL and testbench
======================================

ASYNC_COUNTER_BLOCK -- requirements
Module: async_counter

Interface
REQ-001 SHALL have parameter N, default 4, meaning the counter width in bits; legal range 1..32.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port q, output, N bits, the current count value, driven directly from registers.
REQ-005 SHALL use exactly one clock domain (clk) for all state; no derived, gated or ripple clocks.

Function
REQ-006 SHALL count up by 1 on every rising clk edge where reset_n is 0.
REQ-007 SHALL implement the count as a toggle chain: bit 0 toggles on every counting edge; bit i (i>0) toggles only when bits 0..i-1 are all 1 before the edge.
REQ-008 SHALL produce results identical to binary addition q_next = (q + 1) mod 2^N.
REQ-009 SHALL wrap from 2^N-1 (all ones) to 0 on the next counting edge, with no stall and no extra cycle.
REQ-010 SHALL update all N bits of q on the same clk edge; q SHALL show no intermediate ripple values between edges.
REQ-011 SHALL have 1-cycle latency: the value produced by an edge is visible on q immediately after that edge.
REQ-012 SHALL have no enable, load or direction control; counting is unconditional when not in reset.
REQ-013 SHALL support N=1, where q alternates 0,1,0,1 on successive counting edges.

Reset
REQ-014 SHALL load q to 0 on any rising clk edge where reset_n is 1.
REQ-015 SHALL give reset priority over counting: when reset_n is 1 at an edge, no increment occurs at that edge.
REQ-016 SHALL leave q unchanged when reset_n changes between clk edges; reset acts only at rising edges.
REQ-017 SHALL apply a reset asserted mid-count at the next rising edge, giving q=0 regardless of the current value, including all ones.
REQ-018 SHALL produce q=1 at the first counting edge after reset_n returns to 0, when N>=1.
REQ-019 SHALL leave q undefined after power-up until the first reset edge; the bench SHALL apply reset before checking q.

Verification
REQ-020 SHALL pass this scenario: N=4; hold reset_n=1 for 2 edges, then 0 -> q=0 after the reset edges, then q=1,2,3 on the next three edges.
REQ-021 SHALL pass this scenario: N=4; count 15 edges from 0 -> q=15; the 16th edge gives q=0; 50 edges from reset give q=50 mod 16=2.
REQ-022 SHALL pass this scenario: N=4; at q=7, assert reset_n=1 for one edge -> q=0 at that edge; on deassert, q=1 at the next edge.
REQ-023 SHALL pass this scenario: N=4; at q=15, assert reset_n=1 -> q=0 at that edge, and the count does not wrap first.
REQ-024 SHALL pass this scenario: N=4; pulse reset_n high and back low between two rising edges -> q continues incrementing, with no reset.
REQ-025 SHALL pass this scenario: N=1 and N=8; run 2^N+1 edges after reset -> q=1, checked every cycle against (edges mod 2^N).

Source files
------------

// File: rtl/async_counter_block.sv
// ---------------------------------------------------------------------------
// async_counter_block
//   Free-running N-bit up counter built as a synchronous toggle chain.
//   Every bit is a flop on clk. There are no ripple or derived clocks.
//   Bit i toggles when all lower bits are one. This is the same as q + 1,
//   wrapping from all ones to zero, and every bit changes on the same edge.
//
// Ports
//   clk      in   single clock; all state updates on its rising edge
//   reset_n  in   synchronous reset, ACTIVE HIGH despite the name:
//                 q <= 0 on any rising edge where reset_n == 1
//   q        out  [N-1:0] count value, straight from the flops
//
// Parameters
//   N        counter width, 1..32
// ---------------------------------------------------------------------------

// One stage of the toggle chain: a T flop with synchronous clear.
module async_counter_tbit (
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset_n)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end
endmodule

module async_counter_block #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic [N-1:0] q
);
    // tgl[i] is 1 when bits 0..i-1 are all one. Bit 0 always toggles.
    // The chain is combinational and feeds D-side enables, so q never
    // shows intermediate values between edges.
    logic [N-1:0] tgl;

    assign tgl[0] = 1'b1;

    genvar i;
    generate
        for (i = 1; i < N; i++) begin : g_chain
            assign tgl[i] = tgl[i-1] & q[i-1];
        end

        for (i = 0; i < N; i++) begin : g_bit
            async_counter_tbit u_tbit (
                .clk     (clk),
                .reset_n (reset_n),
                .t       (tgl[i]),
                .q       (q[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_async_counter_block.sv
// ---------------------------------------------------------------------------
// tb_async_counter_block
//   Runs three counters (N=4, N=1, N=8) from one clock and one reset.
//   The driver applies reset_n for each edge and pushes the q values it
//   expects after that edge into a scoreboard. The N=4 values are written
//   out by hand per vector. The N=1 and N=8 values come from an
//   edges-since-reset count.
//   The monitor samples 1 time unit after each rising edge. It pops one
//   entry per edge and compares it against all three counters.
// ---------------------------------------------------------------------------
module tb_async_counter_block;
    logic       clk;
    logic       reset_n;
    logic [3:0] q4;
    logic [0:0] q1;
    logic [7:0] q8;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] e4;
        logic       e1;
        logic [7:0] e8;
        int         vec;
    } exp_t;

    exp_t sb[$];
    int   edges = 0;   // counting edges since last reset edge
    int   vec_id = 0;

    async_counter_block #(.N(4)) dut4 (.clk(clk), .reset_n(reset_n), .q(q4));
    async_counter_block #(.N(1)) dut1 (.clk(clk), .reset_n(reset_n), .q(q1));
    async_counter_block #(.N(8)) dut8 (.clk(clk), .reset_n(reset_n), .q(q8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector = one rising edge. Inputs change 2 units after the
    // previous edge, well away from the edge. With pulse set, reset_n goes
    // high and back low between edges, and q must not react.
    task automatic step(input logic rst, input logic pulse, input logic [3:0] exp4);
        exp_t e;
        @(posedge clk);
        #2;
        reset_n = rst;
        if (pulse) begin
            #1 reset_n = 1'b1;
            #1 reset_n = 1'b0;
        end
        edges  = rst ? 0 : edges + 1;
        e.e4   = exp4;
        e.e1   = edges[0];
        e.e8   = edges[7:0];
        e.vec  = vec_id;
        vec_id++;
        sb.push_back(e);
    endtask

    // Monitor: decoupled from the driver and fed only by the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (q4 !== e.e4) begin
                n_fail++;
                $display("FAIL q4 vec %0d: got %0d expected %0d", e.vec, q4, e.e4);
            end
            n_tests++;
            if (q1[0] !== e.e1) begin
                n_fail++;
                $display("FAIL q1 vec %0d: got %0b expected %0b", e.vec, q1[0], e.e1);
            end
            n_tests++;
            if (q8 !== e.e8) begin
                n_fail++;
                $display("FAIL q8 vec %0d: got %0d expected %0d", e.vec, q8, e.e8);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // q is undefined until the first reset edge, so nothing is queued
        // for that edge.
        reset_n = 1'b1;

        // Two reset edges give 0, then 1, 2, 3 after release.
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd1);
        step(1'b0, 1'b0, 4'd2);
        step(1'b0, 1'b0, 4'd3);

        // Count on to 7, reset for one edge at q=7, then q=1 after release.
        step(1'b0, 1'b0, 4'd4);
        step(1'b0, 1'b0, 4'd5);
        step(1'b0, 1'b0, 4'd6);
        step(1'b0, 1'b0, 4'd7);
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd1);

        // 50 edges from reset. This passes 15, wraps 15->0 on edge 16,
        // and ends at 50 mod 16 = 2.
        step(1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 50; k++) begin
            logic [3:0] ev;
            ev = 4'(k % 16);
            step(1'b0, 1'b0, ev);
        end

        // Reset taken at all ones: q goes to 0 with no wrap step first.
        step(1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 15; k++) begin
            logic [3:0] ev;
            ev = 4'(k);
            step(1'b0, 1'b0, ev);
        end
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd1);

        // Reset pulses between edges are ignored.
        step(1'b0, 1'b1, 4'd2);
        step(1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b0, 4'd4);

        // 257 edges after reset. The N=8 counter ends at 1 and the N=1
        // counter alternates every edge.
        step(1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 257; k++) begin
            logic [3:0] ev;
            ev = 4'(k % 16);
            step(1'b0, 1'b0, ev);
        end

        // Let the monitor drain, with a bounded wait.
        for (int w = 0; w < 10 && sb.size() > 0; w++)
            @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
